rv32im_muldiv_seq: RTL and testbench
====================================

Name: rv32im_muldiv_seq

Overview:
Multi-cycle sequencer for the M-extension operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) produced by the decode stage.
- Accepts one operation at a time and runs an iterative shift-add multiply or restoring divide.
- Stalls issue via `busy_o` and returns the result with its destination register tag for writeback.
- Sits beside the single-cycle ALU in the execute stage; the control unit steers M-ops here instead of the ALU.

Parameters:
- `DATA_WIDTH`, 32, operand/result width (XLEN).
- `REG_ADDR_WIDTH`, 5, register address width.

Ports:
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `start_i`  input  1  request; sampled only when `ready_o`=1.
- `op_i`  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data_i`  input  DATA_WIDTH  operand A (multiplicand/dividend).
- `rs2_data_i`  input  DATA_WIDTH  operand B (multiplier/divisor).
- `rd_addr_i`  input  REG_ADDR_WIDTH  destination tag.
- `flush_i`  input  1  abort the current operation (pipeline flush/trap).
- `ready_o`  output  1  high in IDLE only (combinational from state).
- `busy_o`  output  1  high in CALC, FIX, DONE.
- `done_o`  output  1  one-cycle pulse; result valid.
- `result_o`  output  DATA_WIDTH  result; held stable from done until the next done.
- `rd_addr_o`  output  REG_ADDR_WIDTH  tag captured at start; valid with `done_o`.
- `reg_w_o`  output  1  equals `done_o` AND (`rd_addr_o`≠0).

Behaviour:
- Reset (`rst_n`=0, asynchronous): state=IDLE, `done_o`=0, `busy_o`=0, `ready_o`=1, `result_o`=0, `rd_addr_o`=0, `reg_w_o`=0, all internal accumulators/counters=0.
- FSM states: IDLE, CALC, FIX, DONE.
- Start capture: in IDLE with `start_i`=1, the edge captures operands, op and tag.
  - Signed operands are converted to magnitudes.
  - Result sign is recorded:
    - MUL/MULH: A sign XOR B sign.
    - MULHSU: A sign only.
    - DIV: A sign XOR B sign.
    - REM: A sign.
  - The iteration counter loads `DATA_WIDTH`.
- Special-case divide (detected at start, next state DONE directly; `done_o` high the cycle after the start cycle):
  - Divisor = 0:
    - DIV/DIVU: result = all ones.
    - REM/REMU: result = rs1.
  - DIV/REM with A = 0x80000000 and B = 0xFFFFFFFF:
    - DIV: result = 0x80000000.
    - REM: result = 0.
- Normal path: IDLE→CALC.
  - CALC runs exactly `DATA_WIDTH` cycles, one bit per cycle.
    - Multiply: 2×DATA_WIDTH-bit product, shift-add.
    - Divide: restoring; quotient and remainder DATA_WIDTH each.
  - Counter decrements each cycle; at count 1 → FIX.
  - FIX (one cycle): conditional two's-complement negation.
    - Multiply: on the full 64-bit product.
    - DIV: on the quotient.
    - REM: on the remainder.
    - Then select the result: low word for MUL, high word for MULH/MULHSU/MULHU, quotient or remainder for divides.
  - FIX→DONE.
- DONE: `done_o`=1 for exactly one cycle, then →IDLE. A `start_i` in DONE is ignored; `ready_o` returns next cycle.
- Latency: with start accepted in cycle 0, `done_o` is high in cycle `DATA_WIDTH`+2 (34 at default); special cases in cycle 1.
- `start_i` while not in IDLE: ignored; no side effects on captured operands.
- `flush_i`:
  - Synchronous.
  - In any non-IDLE state: next state IDLE; no `done_o`; `result_o`/`rd_addr_o` keep previous values.
  - `flush_i` and `start_i` together in IDLE: start is dropped.
  - Flush has priority over the DONE pulse: flush asserted in the cycle before DONE suppresses it.
- Async reset mid-operation: immediate return to reset values; no `done_o`.
- Widths: all arithmetic is modulo 2^DATA_WIDTH (2^(2·DATA_WIDTH) for the product); no exceptions raised.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (−3), rd=5 → `done_o` in cycle 34, `result_o`=0xFFFFFFEB, `rd_addr_o`=5, `reg_w_o`=1.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIVU 100/7 → 14, REMU → 2; DIV −7/2 → 0xFFFFFFFD, REM −7/2 → 0xFFFFFFFF; each completes in cycle 34.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, `done_o` in cycle 1; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, cycle 1.
- Start DIVU, pulse `flush_i` at cycle 10 → no `done_o`, `ready_o`=1 at cycle 11, `result_o` unchanged; a new MUL 3×4 then yields 12 at cycle 34 relative to its own start.
- Second `start_i` at cycle 5 of a busy op with different operands → ignored, first result correct. Deassert `rst_n` at cycle 20 → outputs at reset values immediately; rd=0 op → `done_o`=1, `reg_w_o`=0.

Source files
------------

// File: rtl/rv32im_muldiv_seq.sv
// rv32im_muldiv_seq
// Iterative sequencer for the RV32 M-extension operations. It accepts one
// operation at a time. Multiplies run as 32 cycles of shift-add, and divides
// run as 32 cycles of restoring division, both on operand magnitudes. A single
// fix-up cycle then applies the result sign and selects the result word.
// Divide by zero and signed overflow finish directly, one cycle after start.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             request, sampled only while ready_o is high
//   op_i                funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_data_i          operand A (multiplicand / dividend)
//   rs2_data_i          operand B (multiplier / divisor)
//   rd_addr_i           destination register tag
//   flush_i             abort any operation in flight
//   ready_o             idle and able to accept a request
//   busy_o              operation in flight (CALC, FIX, DONE)
//   done_o              one-cycle result-valid pulse
//   result_o            result, held until the next done
//   rd_addr_o           destination tag, valid with done_o
//   reg_w_o             register write enable (done and rd != x0)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i; operands captured on acceptance
// CALC  | one multiply/divide bit per cycle, DATA_WIDTH cycles
// FIX   | sign correction and result word select
// DONE  | result presented, done_o high for one cycle

module rv32im_muldiv_seq #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [2:0]                op_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                      flush_i,
    output logic                      ready_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [DATA_WIDTH-1:0]     result_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic                      reg_w_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]                op_q;
    logic                      neg_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [DATA_WIDTH-1:0]     acc_hi_q;
    logic [DATA_WIDTH-1:0]     acc_lo_q;
    logic [DATA_WIDTH-1:0]     opnd_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;

    // ---------------- start decode ----------------
    logic                  is_div;
    logic                  a_signed, b_signed;
    logic                  a_neg, b_neg, res_neg;
    logic [DATA_WIDTH-1:0] a_mag, b_mag;
    logic                  div_zero, div_ovf, special;
    logic [DATA_WIDTH-1:0] special_res;
    logic                  accept;

    always_comb begin
        is_div   = op_i[2];
        // A is signed for MUL, MULH, MULHSU, DIV, REM; B for MUL, MULH, DIV, REM.
        a_signed = (op_i == 3'b000) || (op_i == 3'b001) || (op_i == 3'b010) ||
                   (op_i == 3'b100) || (op_i == 3'b110);
        b_signed = (op_i == 3'b000) || (op_i == 3'b001) ||
                   (op_i == 3'b100) || (op_i == 3'b110);
        a_neg    = a_signed & rs1_data_i[DATA_WIDTH-1];
        b_neg    = b_signed & rs2_data_i[DATA_WIDTH-1];
        a_mag    = a_neg ? (~rs1_data_i + 1'b1) : rs1_data_i;
        b_mag    = b_neg ? (~rs2_data_i + 1'b1) : rs2_data_i;
        // The remainder takes the sign of the dividend. All other signed ops
        // take the XOR of both operand signs; b_neg is already 0 for MULHSU.
        res_neg  = (is_div && op_i[1]) ? a_neg : (a_neg ^ b_neg);

        div_zero = (rs2_data_i == '0);
        div_ovf  = !op_i[0] && (rs1_data_i == SMIN) && (rs2_data_i == '1);
        special  = is_div && (div_zero || div_ovf);
        if (div_zero)
            special_res = op_i[1] ? rs1_data_i : '1;
        else
            special_res = op_i[1] ? '0 : SMIN;

        accept = (state_q == S_IDLE) && start_i && !flush_i;
    end

    // ---------------- per-cycle iteration ----------------
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH:0]   div_diff;
    logic [DATA_WIDTH-1:0] hi_next, lo_next;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[DATA_WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            // Partial remainder stays below the divisor, so bit DATA_WIDTH of
            // the difference is a clean borrow flag.
            if (!div_diff[DATA_WIDTH]) begin
                hi_next = div_diff[DATA_WIDTH-1:0];
                lo_next = {acc_lo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                hi_next = div_shift[DATA_WIDTH-1:0];
                lo_next = {acc_lo_q[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            // The multiplier shifts out of the low half as the product shifts in.
            hi_next = mul_sum[DATA_WIDTH:1];
            lo_next = {mul_sum[0], acc_lo_q[DATA_WIDTH-1:1]};
        end
    end

    // ---------------- fix-up ----------------
    logic [2*DATA_WIDTH-1:0] prod_raw, prod_fix;
    logic [DATA_WIDTH-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_raw = {acc_hi_q, acc_lo_q};
        prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
        quo_fix  = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_fix  = neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
        case (op_q)
            3'b000:         fix_res = prod_fix[DATA_WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:         fix_res = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            3'b100, 3'b101: fix_res = quo_fix;
            default:        fix_res = rem_fix;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (flush_i)
                    state_d = S_IDLE;
                else if (cnt_q == CNT_W'(1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                state_d = flush_i ? S_IDLE : S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready_o = (state_q == S_IDLE);
    assign busy_o  = !ready_o;
    assign done_o  = (state_q == S_DONE);
    assign reg_w_o = done_o && (rd_addr_o != '0);

    // ---------------- datapath ----------------
    // result_o and rd_addr_o load only on entry to DONE. A flushed operation
    // therefore leaves the previous result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            rd_q      <= '0;
            result_o  <= '0;
            rd_addr_o <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= op_i;
                        neg_q    <= res_neg;
                        cnt_q    <= CNT_W'(DATA_WIDTH);
                        rd_q     <= rd_addr_i;
                        acc_hi_q <= '0;
                        acc_lo_q <= is_div ? a_mag : b_mag;
                        opnd_q   <= is_div ? b_mag : a_mag;
                        if (special) begin
                            result_o  <= special_res;
                            rd_addr_o <= rd_addr_i;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush_i) begin
                        cnt_q    <= cnt_q - 1'b1;
                        acc_hi_q <= hi_next;
                        acc_lo_q <= lo_next;
                    end
                end
                S_FIX: begin
                    if (!flush_i) begin
                        result_o  <= fix_res;
                        rd_addr_o <= rd_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32im_muldiv_seq.sv
// Testbench for rv32im_muldiv_seq. Stimulus pushes expected results, tags and
// due cycles into a scoreboard queue. A monitor pops the queue on every
// done_o and compares the DUT outputs against the queued entry. Expected
// values come from plain integer arithmetic on the RISC-V M rules.

module tb_rv32im_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        ready_o, busy_o, done_o, reg_w_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    rv32im_muldiv_seq #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_addr_i  (rd_addr_i),
        .flush_i    (flush_i),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_addr_o  (rd_addr_o),
        .reg_w_o    (reg_w_o)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges++;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;

    localparam logic [31:0] SMIN = 32'h8000_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        int          sa;
        int          sb;
        longint      p;
        logic [63:0] up;
        logic [31:0] r;
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            3'd0: begin p = longint'(sa) * longint'(sb); r = p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            3'd4: begin
                if (b == 0)                      r = 32'hFFFF_FFFF;
                else if (a == SMIN && b == '1)   r = SMIN;
                else                             r = sa / sb;
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0)                      r = a;
                else if (a == SMIN && b == '1)   r = '0;
                else                             r = sa % sb;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == SMIN && b == '1));
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return SMIN;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: sample away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done result=%h expected no done", result_o);
                end else begin
                    e = sb_q.pop_front();
                    chk("result",   result_o, e.res);
                    chk("rd_addr",  {27'b0, rd_addr_o}, {27'b0, e.rd});
                    chk("reg_w",    {31'b0, reg_w_o}, {31'b0, (e.rd != 0)});
                    chk("latency",  edges, e.due);
                    chk("busy_on_done", {31'b0, busy_o}, 32'd1);
                    last_res = e.res;
                end
            end
        end
    end

    // Called at a negedge; returns at the following negedge with start dropped.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int e0);
        int   n;
        exp_t e;
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout ready=%b expected=1", ready_o);
        end
        op_i       = op;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_addr_i  = rd;
        start_i    = 1'b1;
        e0         = edges;
        e.res      = ref_model(op, a, b);
        e.rd       = rd;
        e.due      = edges + (is_special(op, a, b) ? 1 : 34);
        sb_q.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !ready_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d expected=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},  {31'b0, ready_o}, 32'd1);
        chk({tag, "_busy"},   {31'b0, busy_o},  32'd0);
        chk({tag, "_done"},   {31'b0, done_o},  32'd0);
        chk({tag, "_result"}, result_o, 32'd0);
        chk({tag, "_rd"},     {27'b0, rd_addr_o}, 32'd0);
        chk({tag, "_reg_w"},  {31'b0, reg_w_o}, 32'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } vec_t;

    vec_t dir[$] = '{
        '{3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3},
        '{3'd5, 32'd100,      32'd7,         5'd4},
        '{3'd7, 32'd100,      32'd7,         5'd6},
        '{3'd4, 32'hFFFF_FFF9, 32'd2,        5'd7},
        '{3'd6, 32'hFFFF_FFF9, 32'd2,        5'd8},
        '{3'd4, 32'd5,        32'd0,         5'd9},
        '{3'd6, 32'd5,        32'd0,         5'd10},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12},
        '{3'd0, 32'd3,        32'd5,         5'd0}
    };

    initial begin
        int e0;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (dir[i]) begin
            issue(dir[i].op, dir[i].a, dir[i].b, dir[i].rd, e0);
            drain();
        end

        // Start while busy with different operands must not disturb the first op.
        issue(3'd2, 32'hDEAD_BEEF, 32'h1234_5678, 5'd13, e0);
        while (edges < e0 + 5) @(negedge clk);
        chk("busy_mid_op", {31'b0, busy_o}, 32'd1);
        op_i       = 3'd4;
        rs1_data_i = 32'd99;
        rs2_data_i = 32'd0;
        rd_addr_i  = 5'd20;
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        drain();

        // Flush mid-divide: no done, ready the next cycle, result held.
        issue(3'd5, 32'd1000, 32'd3, 5'd14, e0);
        while (edges < e0 + 10) @(negedge clk);
        flush_i = 1'b1;
        sb_q.delete(sb_q.size() - 1);
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_ready",  {31'b0, ready_o}, 32'd1);
        chk("flush_result", result_o, last_res);
        repeat (40) @(negedge clk);
        issue(3'd0, 32'd3, 32'd4, 5'd15, e0);
        drain();

        // Start together with flush in IDLE is dropped.
        op_i       = 3'd0;
        rs1_data_i = 32'd9;
        rs2_data_i = 32'd9;
        rd_addr_i  = 5'd16;
        start_i    = 1'b1;
        flush_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_start_dropped", {31'b0, ready_o}, 32'd1);
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of an operation.
        issue(3'd3, $urandom, $urandom, 5'd17, e0);
        while (edges < e0 + 20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_reset_outputs("async_reset");
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 60; k++) begin
            logic [2:0] rop;
            rop = 3'($urandom_range(0, 7));
            issue(rop, pick_operand(), pick_operand(), 5'($urandom_range(0, 31)), e0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time=%0t limit=1000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
